// File: rtl/logs_pwm_demod.sv
// logs_pwm_demod: counts high clocks of a PWM stream per window and queues the counts
module logs_pwm_demod #(
    parameter int WIN_BITS    = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic [WIN_BITS:0] sample_out,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overflow,
    input  logic              clear_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [SYNC_STAGES-1:0] sync;
    logic [WIN_BITS-1:0]    wcnt;
    logic [WIN_BITS:0]      acc;
    logic [WIN_BITS:0]      sum;
    logic [WIN_BITS:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]          rd;
    logic [AW-1:0]          wr;
    logic [CW-1:0]          cnt;
    logic                   close;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;

    // window close, FIFO handshake decisions and the gated head output
    always_comb begin
        sample_valid = cnt != '0;
        close = &wcnt;
        sum = acc + {{WIN_BITS{1'b0}}, sync[SYNC_STAGES-1]};
        full = cnt == CW'(FIFO_DEPTH);
        pop = sample_valid && sample_ready;
        push = close && (!full || pop);
        drop = close && full && !pop;
        sample_out = sample_valid ? mem[rd] : '0;
    end

    // synchronise pwm_in, run the free-running window and accumulate high clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            wcnt <= '0;
            acc  <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
            wcnt <= wcnt + WIN_BITS'(1);
            acc  <= close ? '0 : sum;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag (a drop beats a clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd       <= '0;
            wr       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            rd       <= pop ? rd + AW'(1) : rd;
            wr       <= push ? wr + AW'(1) : wr;
            cnt      <= cnt + CW'(push) - CW'(pop);
            overflow <= drop || (overflow && !clear_ovf);
        end
    end

    // sample storage; contents are only observed through a valid head
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= sum;
    end
endmodule

// File: doc/logs_pwm_demod.md
# logs_pwm_demod

Recovers PCM sample values from a 1-bit PWM audio stream, such as the mixer output of the logistic-map sonifier. Each sample is the number of high clocks seen in a fixed window of 2^WIN_BITS clocks. Samples go through a small FIFO and leave on a valid/ready interface. The block serves as an on-chip loopback monitor and as the bench-side reference receiver for the sound path.

## Interface

Parameters:
- WIN_BITS, 8: log2 of the window length in clocks; sample width is WIN_BITS+1.
- FIFO_DEPTH, 4: sample FIFO entries; must be a power of two, ≥2.
- SYNC_STAGES, 2: synchroniser flops on pwm_in; must be ≥2.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- pwm_in  input  1  PWM audio stream; may be asynchronous to clk.
- sample_out  output  WIN_BITS+1  FIFO head: high-clock count of the oldest unread window.
- sample_valid  output  1  FIFO non-empty.
- sample_ready  input  1  consumer accepts sample_out this cycle.
- overflow  output  1  sticky: a sample was dropped because the FIFO was full.
- clear_ovf  input  1  synchronous clear of overflow.

## Operation

- **Reset.** While rst_n is low, asynchronously clear the following:
  - synchroniser flops, window counter wcnt, accumulator acc, FIFO pointers/count, overflow;
  - outputs: sample_out=0, sample_valid=0, overflow=0.
- **Synchroniser.** pwm_in passes through SYNC_STAGES flops; call the last stage s.
- **Window counter.** wcnt is WIN_BITS wide and increments every clock, wrapping from 2^WIN_BITS−1 to 0. There is no idle state; windows run back to back.
- **Accumulator.** acc is WIN_BITS+1 bits.
  - When wcnt≠max: acc ← acc+s.
  - When wcnt=max (window close): push acc+s into the FIFO and set acc ← 0.
  - Sample range is 0..2^WIN_BITS inclusive, so acc never wraps.
- **FIFO push.**
  - If not full, write the pushed sample at the tail.
  - If full and no pop this cycle, drop the new sample (FIFO contents unchanged) and set overflow.
  - If full and a pop occurs the same cycle, perform both; no overflow.
- **FIFO pop.** Occurs when sample_valid && sample_ready. sample_ready while the FIFO is empty has no effect.
- **Output order.** sample_out always reflects the head entry, in strict FIFO order.
- **overflow.**
  - Set on a drop; stays set until clear_ovf.
  - If clear_ovf and a drop occur in the same cycle, set wins (overflow stays 1).
- **Reset mid-operation.** Discards a partial window and all FIFO contents. The first window after release is full length.

## Timing

- **Reset release.** Let edge 1 be the first rising edge with rst_n high.
  - wcnt=0 at edge 1, so edge 2^WIN_BITS is the first window close.
- **Input latency.** The s value accumulated at edge k is the pwm_in level captured SYNC_STAGES edges earlier.
  - The first window after reset therefore sees SYNC_STAGES zero bits from the synchroniser's reset state.
- **First sample.** sample_valid rises immediately after edge 2^WIN_BITS. A sample is visible one cycle after its window closes.
- **Sample rate.** One sample every 2^WIN_BITS clocks. A consumer holding sample_ready=1 never causes overflow.
- **Full FIFO.** With sample_ready=0, the FIFO fills after FIFO_DEPTH windows. The next window close sets overflow.
- **Pop.** The pop takes effect at the edge where sample_valid && sample_ready. The next entry (or sample_valid=0) is visible after that edge.
- **clear_ovf.** overflow goes low the cycle after clear_ovf is sampled high, absent a simultaneous drop.
- **Throughput.** No bubbles: push and pop may occur in the same cycle at any occupancy.

## Test plan

All scenarios use defaults unless stated (WIN_BITS=8, FIFO_DEPTH=4, SYNC_STAGES=2).

1. **Constant high.** Hold pwm_in=1 from reset, sample_ready=1 → first sample 254, all later samples 256. sample_valid pulses for one cycle every 256 clocks, first after edge 256.
2. **50% duty.** Drive 50% duty at period 16 clocks, phase-aligned so each window holds an integer number of periods, sample_ready=1 → every sample after the first is 128. pwm_in=0 constant → all samples 0.
3. **Backpressure.** Hold sample_ready=0 for 5 windows with constant-high input → 4 entries held, overflow=1 after the 5th close. Draining yields 254, 256, 256, 256, then sample_valid=0.
4. **Overflow clear.**
   - clear_ovf pulse alone → overflow low next cycle.
   - clear_ovf coincident with a drop → overflow stays 1.
   - Pop coincident with a full-FIFO push → no overflow, count stays 4.
5. **Async reset mid-window.** Assert rst_n low at wcnt=100 with 2 samples queued → sample_valid, overflow, sample_out drop to 0 immediately, without waiting for a clock edge. After release, the next sample appears after edge 256 with value 254 for constant-high input.
6. **Random stimulus.** Random pwm_in and random sample_ready over ≥64 windows, with WIN_BITS=4 and FIFO_DEPTH=2 → popped samples match a scoreboard model count-for-count. overflow asserts exactly when the model drops a sample.
